// File: rtl/char_overlay_render_if.sv
// Video-in / video-out / glyph-decoder signal bundle for the character overlay renderer.
interface char_overlay_render_if;
  logic [11:0]  i_hcnt;
  logic [11:0]  i_vcnt;
  logic         i_de;
  logic         i_hs;
  logic         i_vs;
  logic [15:0]  i_data;
  logic [4:0]   str_base;
  logic         overlay_en;
  logic [4:0]   char2;
  logic [255:0] char2_array;
  logic         o_de;
  logic         o_hs;
  logic         o_vs;
  logic [15:0]  o_data;

  // Video source, control and glyph decoder side
  modport master (
    output i_hcnt, i_vcnt, i_de, i_hs, i_vs, i_data, str_base, overlay_en, char2_array,
    input  char2, o_de, o_hs, o_vs, o_data
  );

  // Overlay renderer side
  modport slave (
    input  i_hcnt, i_vcnt, i_de, i_hs, i_vs, i_data, str_base, overlay_en, char2_array,
    output char2, o_de, o_hs, o_vs, o_data
  );
endinterface

// File: rtl/char_overlay_render.sv
// Draws CHAR_NUM 16x16 glyphs onto the video stream at a fixed position. Three-stage pipeline:
// window decode, glyph index to decoder, bitmap lookup and pixel replace. Timing is delayed
// by exactly three clocks on every path.
module char_overlay_render #(
  parameter logic [11:0] H_START  = 12'd16,
  parameter logic [11:0] V_START  = 12'd16,
  parameter int unsigned CHAR_NUM = 2,
  parameter logic [15:0] FG_COLOR = 16'hF800
) (
  input logic                  clk,
  input logic                  rst_n,
  char_overlay_render_if.slave bus
);

  localparam logic [11:0] H_END = H_START + 12'(16 * CHAR_NUM - 1);
  localparam logic [11:0] V_END = V_START + 12'd15;

  // Frame-latched controls
  logic       vs_prev_q;
  logic [4:0] base_q;
  logic       en_q;

  // Stage 1
  logic        win1_q;
  logic [2:0]  slot1_q;
  logic [3:0]  col1_q;
  logic [3:0]  row1_q;
  logic        de1_q, hs1_q, vs1_q;
  logic [15:0] data1_q;

  // Stage 2 (char2 itself is the stage-2 glyph index register)
  logic        win2_q;
  logic [3:0]  col2_q;
  logic [3:0]  row2_q;
  logic        de2_q, hs2_q, vs2_q;
  logic [15:0] data2_q;

  // Window decode of the incoming pixel
  logic [6:0] dx;
  logic [3:0] dy;
  logic       in_win;
  logic       pix_bit;

  assign dx = 7'(bus.i_hcnt - H_START);
  assign dy = 4'(bus.i_vcnt - V_START);
  assign in_win = bus.i_de & en_q &
                  (bus.i_hcnt >= H_START) & (bus.i_hcnt <= H_END) &
                  (bus.i_vcnt >= V_START) & (bus.i_vcnt <= V_END);

  // Row-major bitmap, MSB is row 0 column 0; a 0 bit means foreground.
  assign pix_bit = bus.char2_array[8'd255 - {row2_q, col2_q}];

  // Latch string base and enable on the rising edge of vsync only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
      base_q    <= '0;
      en_q      <= 1'b0;
    end else begin
      vs_prev_q <= bus.i_vs;
      if (bus.i_vs && !vs_prev_q) begin
        base_q <= bus.str_base;
        en_q   <= bus.overlay_en;
      end
    end
  end

  // Stage 1: register window flag, glyph slot and in-glyph coordinates with the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win1_q  <= 1'b0;
      slot1_q <= '0;
      col1_q  <= '0;
      row1_q  <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      data1_q <= '0;
    end else begin
      win1_q  <= in_win;
      slot1_q <= dx[6:4];
      col1_q  <= dx[3:0];
      row1_q  <= dy;
      de1_q   <= bus.i_de;
      hs1_q   <= bus.i_hs;
      vs1_q   <= bus.i_vs;
      data1_q <= bus.i_data;
    end
  end

  // Stage 2: drive glyph index to the decoder (5-bit wrap), carry the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.char2 <= '0;
      win2_q    <= 1'b0;
      col2_q    <= '0;
      row2_q    <= '0;
      de2_q     <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      data2_q   <= '0;
    end else begin
      bus.char2 <= base_q + {2'b00, slot1_q};
      win2_q    <= win1_q;
      col2_q    <= col1_q;
      row2_q    <= row1_q;
      de2_q     <= de1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      data2_q   <= data1_q;
    end
  end

  // Stage 3: replace foreground pixels inside the window, delay timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_de   <= 1'b0;
      bus.o_hs   <= 1'b0;
      bus.o_vs   <= 1'b0;
      bus.o_data <= '0;
    end else begin
      bus.o_de   <= de2_q;
      bus.o_hs   <= hs2_q;
      bus.o_vs   <= vs2_q;
      bus.o_data <= (win2_q && !pix_bit) ? FG_COLOR : data2_q;
    end
  end

endmodule

// File: tb/tb_char_overlay_render.sv
// Randomized bench for char_overlay_render with a frame-level reference model and a stand-in
// glyph decoder. Small 80x44 frames (64x40 active) keep the run short.
module tb_char_overlay_render;

  localparam int HS = 16;
  localparam int VS = 16;
  localparam int CN = 2;
  localparam logic [15:0] FG = 16'hF800;
  localparam int HT = 80;
  localparam int VT = 44;
  localparam int HA = 64;
  localparam int VA = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   pins = 0;
  int   cur_f = -1;

  char_overlay_render_if bus ();

  char_overlay_render #(
    .H_START  (12'(HS)),
    .V_START  (12'(VS)),
    .CHAR_NUM (CN),
    .FG_COLOR (FG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in decoder: indices above 17 give the all-foreground default glyph
  function automatic logic [255:0] glyph(input logic [4:0] idx);
    logic [255:0] g;
    logic [15:0]  r16;
    g = '0;
    if (idx > 5'd17) return g;
    for (int r = 0; r < 16; r++) begin
      r16 = 16'(((int'(idx) + 1) * 40503) ^ (r * 29837) ^ (r * int'(idx) * 7));
      if (idx == 5'd0 && r == 1) r16 = 16'hE00F;
      g[255 - 16 * r -: 16] = r16;
    end
    return g;
  endfunction

  assign bus.char2_array = glyph(bus.char2);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    pins++;
    chk(name, got, exp);
  endtask

  typedef struct {
    int          f, h, v;
    logic        win;
    logic [4:0]  idx;
    logic [15:0] din;
    logic [18:0] exp;
  } ent_t;

  ent_t q[$];
  logic       m_en = 1'b0;
  logic [4:0] m_base = '0;
  logic       m_pvs = 1'b0;

  // Reference model and per-cycle compare
  initial begin : model
    ent_t e, z, p;
    logic [255:0] g;
    logic [15:0]  dout;
    int col, row;
    z = '{f: -1, h: -1, v: -1, win: 1'b0, idx: 5'd0, din: 16'd0, exp: 19'd0};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        q.push_back(z);
        q.push_back(z);
        m_en = 1'b0;
        m_base = '0;
        m_pvs = 1'b0;
        #1;
        chk("reset_out", {8'd0, bus.char2, bus.o_de, bus.o_hs, bus.o_vs, bus.o_data}, 32'd0);
      end else begin
        e.f = cur_f;
        e.h = int'(bus.i_hcnt);
        e.v = int'(bus.i_vcnt);
        e.din = bus.i_data;
        e.win = bus.i_de && m_en && e.h >= HS && e.h <= HS + 16 * CN - 1 &&
                e.v >= VS && e.v <= VS + 15;
        e.idx = e.win ? 5'(int'(m_base) + (e.h - HS) / 16) : 5'd0;
        dout = e.din;
        if (e.win) begin
          g = glyph(e.idx);
          col = (e.h - HS) % 16;
          row = e.v - VS;
          if (g[255 - (row * 16 + col)] == 1'b0) dout = FG;
        end
        e.exp = {bus.i_de, bus.i_hs, bus.i_vs, dout};
        if (bus.i_vs && !m_pvs) begin
          m_base = bus.str_base;
          m_en = bus.overlay_en;
        end
        m_pvs = bus.i_vs;
        q.push_back(e);
        #1;
        p = q.pop_front();
        chk("stream", {13'd0, bus.o_de, bus.o_hs, bus.o_vs, bus.o_data}, {13'd0, p.exp});
        // Hand-derived pins on the output pixel
        if (p.f == 1 && p.v == VS + 1 && p.h >= HS && p.h < HS + 16)
          pin("glyph0_row1", {16'd0, bus.o_data},
              {16'd0, (p.h - HS >= 3 && p.h - HS <= 11) ? FG : p.din});
        if (p.f == 2 && p.h == HS && p.v == VS) pin("passthru_win", {16'd0, bus.o_data}, {16'd0, p.din});
        if (p.f == 3 && p.h == HS - 1 && p.v == VS) pin("edge_left", {16'd0, bus.o_data}, {16'd0, p.din});
        if (p.f == 3 && p.h == HS && p.v == VS + 16) pin("edge_below", {16'd0, bus.o_data}, {16'd0, p.din});
        if (p.f == 3 && p.h == HS + 16 * CN && p.v == VS) pin("edge_right", {16'd0, bus.o_data}, {16'd0, p.din});
        if (p.f == 3 && p.h == HS + 16 * CN - 1 && p.v == VS + 15)
          pin("edge_last", {16'd0, bus.o_data}, {16'd0, FG});
        // Glyph index presented to the decoder for the next pixel in flight
        if (q[0].win) chk("char2", {27'd0, bus.char2}, {27'd0, q[0].idx});
        if (q[0].f == 3 && q[0].v == VS && q[0].h == HS) pin("char2_b30_s0", {27'd0, bus.char2}, 32'd30);
        if (q[0].f == 3 && q[0].v == VS && q[0].h == HS + 16) pin("char2_b30_s1", {27'd0, bus.char2}, 32'd31);
        if (q[0].f == 4 && q[0].v == VS && q[0].h == HS) pin("char2_b31_s0", {27'd0, bus.char2}, 32'd31);
        if (q[0].f == 4 && q[0].v == VS && q[0].h == HS + 16) pin("char2_b31_s1", {27'd0, bus.char2}, 32'd0);
      end
    end
  end

  task automatic run_frame(input int f, input logic [4:0] b0, input logic e0,
                           input int chg_line, input logic [4:0] b1, input logic e1);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        @(negedge clk);
        if (y == 0 && x == 0) begin
          cur_f = f;
          bus.str_base = b0;
          bus.overlay_en = e0;
        end
        if (y == chg_line && x == 0) begin
          bus.str_base = b1;
          bus.overlay_en = e1;
        end
        bus.i_hcnt = 12'(x);
        bus.i_vcnt = 12'(y);
        bus.i_de = (x < HA) && (y < VA);
        bus.i_hs = (x >= 68) && (x < 76);
        bus.i_vs = (y == 42);
        bus.i_data = 16'($urandom);
      end
    end
  endtask

  // Stimulus
  initial begin : drive
    bus.i_hcnt = '0;
    bus.i_vcnt = '0;
    bus.i_de = 1'b1;
    bus.i_hs = 1'b0;
    bus.i_vs = 1'b0;
    bus.i_data = 16'h1234;
    bus.str_base = '0;
    bus.overlay_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {8'd0, bus.char2, bus.o_de, bus.o_hs, bus.o_vs, bus.o_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lat2", {16'd0, bus.o_data}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_lat3", {16'd0, bus.o_data}, 32'h1234);

    run_frame(0, 5'd0, 1'b1, -1, 5'd0, 1'b0);
    run_frame(1, 5'd0, 1'b1, 8, 5'd6, 1'b0);
    run_frame(2, 5'd30, 1'b1, -1, 5'd0, 1'b0);
    run_frame(3, 5'd31, 1'b1, -1, 5'd0, 1'b0);
    for (int f = 4; f < 7; f++)
      run_frame(f, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 39)), 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
    repeat (4) @(negedge clk);
    chk("pin_count", pins, 32'd25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
